// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: round-robin between core (r0) and AES DMA (r1),
// r1 burst lock, and an owner-id FIFO that routes in-order responses back.
module mem_arbiter #(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        r0_req_i,
  input  logic [31:0] r0_addr_i,
  input  logic        r0_we_i,
  input  logic [3:0]  r0_be_i,
  input  logic [31:0] r0_wdata_i,
  output logic        r0_gnt_o,
  output logic        r0_rvalid_o,
  output logic [31:0] r0_rdata_o,
  input  logic        r1_req_i,
  input  logic [31:0] r1_addr_i,
  input  logic        r1_we_i,
  input  logic [3:0]  r1_be_i,
  input  logic [31:0] r1_wdata_i,
  input  logic        r1_burst_i,
  output logic        r1_gnt_o,
  output logic        r1_rvalid_o,
  output logic [31:0] r1_rdata_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);

  localparam int unsigned CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned NW = $clog2(MAX_OUTST + 1);

  typedef enum logic {ARB, BURST} state_e;

  state_e               state_q;
  logic [CW-1:0]        beat_q;
  logic                 rr_q;
  logic [MAX_OUTST-1:0] owner_q;
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [NW-1:0]        count_q;
  logic                 err_q;

  logic sel, eligible, pop, push, full, head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    pop  = mem_rvalid_i & (count_q != '0);
    // A pop in the same cycle frees a slot, so fullness is judged after it.
    full = ((count_q - NW'(pop)) == NW'(MAX_OUTST));
    if (state_q == BURST) begin
      sel      = 1'b1;
      eligible = r1_req_i;
    end else begin
      eligible = r0_req_i | r1_req_i;
      sel      = (r0_req_i & r1_req_i) ? rr_q : r1_req_i;
    end
    mem_req_o = rst_ni & eligible & ~full;
    push      = mem_req_o & mem_gnt_i;
    r0_gnt_o  = push & ~sel;
    r1_gnt_o  = push & sel;

    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (mem_req_o) begin
      mem_addr_o  = sel ? r1_addr_i  : r0_addr_i;
      mem_we_o    = sel ? r1_we_i    : r0_we_i;
      mem_be_o    = sel ? r1_be_i    : r0_be_i;
      mem_wdata_o = sel ? r1_wdata_i : r0_wdata_i;
    end

    head        = owner_q[rd_ptr_q];
    r0_rvalid_o = pop & ~head;
    r1_rvalid_o = pop & head;
    r0_rdata_o  = r0_rvalid_o ? mem_rdata_i : '0;
    r1_rdata_o  = r1_rvalid_o ? mem_rdata_i : '0;
    err_o       = err_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ARB;
      beat_q   <= '0;
      rr_q     <= 1'b0;
      owner_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        ARB: if (push) begin
          rr_q <= ~sel;
          if (sel && r1_burst_i && (BURST_LEN > 1)) begin
            state_q <= BURST;
            beat_q  <= CW'(BURST_LEN - 1);
          end
        end
        BURST: if (push) begin
          beat_q <= beat_q - 1'b1;
          if (beat_q == CW'(1)) state_q <= ARB;
        end
        default: state_q <= ARB;
      endcase

      if (push) begin
        owner_q[wr_ptr_q] <= sel;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + NW'(push) - NW'(pop);
      if (mem_rvalid_i && (count_q == '0)) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run, every cycle
// compared against a queue-based reference model of the arbitration rules.
module tb_mem_arbiter;
  localparam int BL = 4;
  localparam int MO = 2;

  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        r0_req_i = 0, r0_we_i = 0, r0_gnt_o, r0_rvalid_o;
  logic [31:0] r0_addr_i = '0, r0_wdata_i = '0, r0_rdata_o;
  logic [3:0]  r0_be_i = '0;
  logic        r1_req_i = 0, r1_we_i = 0, r1_burst_i = 0, r1_gnt_o, r1_rvalid_o;
  logic [31:0] r1_addr_i = '0, r1_wdata_i = '0, r1_rdata_o;
  logic [3:0]  r1_be_i = '0;
  logic        mem_req_o, mem_we_o, mem_gnt_i = 0, mem_rvalid_i = 0, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i = '0;
  logic [3:0]  mem_be_o;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.BURST_LEN(BL), .MAX_OUTST(MO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .r0_req_i(r0_req_i), .r0_addr_i(r0_addr_i), .r0_we_i(r0_we_i), .r0_be_i(r0_be_i),
    .r0_wdata_i(r0_wdata_i), .r0_gnt_o(r0_gnt_o), .r0_rvalid_o(r0_rvalid_o), .r0_rdata_o(r0_rdata_o),
    .r1_req_i(r1_req_i), .r1_addr_i(r1_addr_i), .r1_we_i(r1_we_i), .r1_be_i(r1_be_i),
    .r1_wdata_i(r1_wdata_i), .r1_burst_i(r1_burst_i), .r1_gnt_o(r1_gnt_o),
    .r1_rvalid_o(r1_rvalid_o), .r1_rdata_o(r1_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  int passed = 0, failed = 0, total = 0;

  // Reference model: outstanding owner ids in issue order, tie priority,
  // remaining locked burst beats, sticky error.
  int mq[$];
  int m_prio = 0;
  int m_left = 0;
  bit m_err  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rand_attr();
    r0_addr_i = $urandom; r0_we_i = 1'($urandom); r0_be_i = 4'($urandom); r0_wdata_i = $urandom;
    r1_addr_i = $urandom; r1_we_i = 1'($urandom); r1_be_i = 4'($urandom); r1_wdata_i = $urandom;
  endtask

  // One clock: drive at posedge+1, compare near the falling edge, advance model at posedge.
  task automatic cycle(input bit q0, input bit q1, input bit bst, input bit g, input bit rv,
                       output bit o0, output bit o1, output bit oreq);
    int  win, head;
    bit  mpop, full, req;
    r0_req_i = q0; r1_req_i = q1; r1_burst_i = bst;
    mem_gnt_i = g; mem_rvalid_i = rv; mem_rdata_i = $urandom;
    mpop = rv && (mq.size() > 0);
    full = (mq.size() - int'(mpop)) >= MO;
    if (m_left > 0)     win = q1 ? 1 : -1;
    else if (q0 && q1)  win = m_prio;
    else if (q0)        win = 0;
    else if (q1)        win = 1;
    else                win = -1;
    req  = (win >= 0) && !full;
    head = mpop ? mq[0] : -1;
    #3;
    check("mem_req",   32'(mem_req_o), 32'(req));
    check("r0_gnt",    32'(r0_gnt_o), 32'(req && g && win == 0));
    check("r1_gnt",    32'(r1_gnt_o), 32'(req && g && win == 1));
    check("mem_addr",  mem_addr_o,  !req ? 32'h0 : (win == 0 ? r0_addr_i : r1_addr_i));
    check("mem_we",    32'(mem_we_o), !req ? 32'h0 : 32'(win == 0 ? r0_we_i : r1_we_i));
    check("mem_be",    32'(mem_be_o), !req ? 32'h0 : 32'(win == 0 ? r0_be_i : r1_be_i));
    check("mem_wdata", mem_wdata_o, !req ? 32'h0 : (win == 0 ? r0_wdata_i : r1_wdata_i));
    check("r0_rvalid", 32'(r0_rvalid_o), 32'(head == 0));
    check("r1_rvalid", 32'(r1_rvalid_o), 32'(head == 1));
    check("r0_rdata",  r0_rdata_o, (head == 0) ? mem_rdata_i : 32'h0);
    check("r1_rdata",  r1_rdata_o, (head == 1) ? mem_rdata_i : 32'h0);
    check("err",       32'(err_o), 32'(m_err));
    o0 = r0_gnt_o; o1 = r1_gnt_o; oreq = mem_req_o;
    @(posedge clk_i);
    if (rv && mq.size() == 0) m_err = 1;
    if (mpop) void'(mq.pop_front());
    if (req && g) begin
      mq.push_back(win);
      if (m_left > 0) m_left--;
      else begin
        m_prio = 1 - win;
        if (win == 1 && bst) m_left = BL - 1;
      end
    end
    #1;
  endtask

  // Asserts reset mid-cycle with both requesters active; outputs must drop at once.
  task automatic do_reset();
    r0_req_i = 1; r1_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 0;
    rst_ni = 0;
    #2;
    check("rst_mem_req", 32'(mem_req_o), 32'h0);
    check("rst_r0_gnt",  32'(r0_gnt_o), 32'h0);
    check("rst_r1_gnt",  32'(r1_gnt_o), 32'h0);
    check("rst_addr",    mem_addr_o, 32'h0);
    check("rst_wdata",   mem_wdata_o, 32'h0);
    check("rst_be",      32'(mem_be_o), 32'h0);
    check("rst_rvalid",  32'({r0_rvalid_o, r1_rvalid_o}), 32'h0);
    check("rst_rdata",   r0_rdata_o | r1_rdata_o, 32'h0);
    check("rst_err",     32'(err_o), 32'h0);
    mq.delete(); m_prio = 0; m_left = 0; m_err = 0;
    @(posedge clk_i); #1;
    rst_ni = 1;
  endtask

  task automatic drain();
    bit a, b, c;
    for (int i = 0; i < 20 && mq.size() > 0; i++) cycle(0, 0, 0, 1, 1, a, b, c);
    check("drained", 32'(mq.size()), 32'h0);
  endtask

  initial begin
    bit g0, g1, rq;
    do_reset();

    // Partial write from r0
    r0_addr_i = 32'h188; r0_we_i = 1; r0_be_i = 4'h3; r0_wdata_i = 32'hDEADBEEF;
    cycle(1, 0, 0, 1, 0, g0, g1, rq);
    check("wr_gnt", 32'(g0), 32'h1);
    cycle(0, 0, 0, 1, 1, g0, g1, rq);

    // Continuous tie with 1-cycle responses: strict alternation, r1 first since r0 just won
    rand_attr();
    for (int i = 0; i < 8; i++) begin
      cycle(1, 1, 0, 1, mq.size() > 0, g0, g1, rq);
      check("alt_r0", 32'(g0), 32'(i % 2 == 1));
      check("alt_r1", 32'(g1), 32'(i % 2 == 0));
    end
    drain();

    // r1 burst of four reads 0x1B8..0x1C4 against a continuously requesting r0
    r1_we_i = 0;
    for (int i = 0; i < 5; i++) begin
      r1_addr_i = 32'h1B8 + 32'(4 * i);
      cycle(1, 1, 1, 1, mq.size() > 0, g0, g1, rq);
      check("burst_r1", 32'(g1), 32'(i < 4));
      check("burst_r0", 32'(g0), 32'(i == 4));
    end
    drain();

    // Memory withholds responses: two grants then stall; pop and grant together
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 0, 1, 0, g0, g1, rq);
      check("stall_gnt", 32'(g0 | g1), 32'(i < 2));
      check("stall_req", 32'(rq), 32'(i < 2));
    end
    cycle(1, 1, 0, 1, 1, g0, g1, rq);
    check("pop_gnt", 32'(g0 | g1), 32'h1);
    drain();

    // Reset after the second beat of a burst; first tie afterwards goes to r0
    cycle(0, 1, 1, 1, 0, g0, g1, rq);
    check("rb_beat1", 32'(g1), 32'h1);
    cycle(1, 1, 1, 1, 1, g0, g1, rq);
    check("rb_beat2", 32'(g1), 32'h1);
    do_reset();
    cycle(1, 1, 0, 1, 0, g0, g1, rq);
    check("post_rst_r0", 32'(g0), 32'h1);
    drain();

    // Spurious response with nothing outstanding
    do_reset();
    cycle(0, 0, 0, 0, 1, g0, g1, rq);
    check("spur_err", 32'(err_o), 32'h1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, g0, g1, rq);
    check("err_sticky", 32'(err_o), 32'h1);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rand_attr();
      cycle($urandom_range(3) != 0, $urandom_range(3) != 0, 1'($urandom),
            $urandom_range(3) != 0, (mq.size() > 0) && ($urandom_range(2) != 0), g0, g1, rq);
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BURST_LEN, default 4, beats a requester 1 burst holds the memory port (one 128-bit AES block).
REQ-002 Parameter MAX_OUTST, default 2, maximum accepted-but-unanswered memory transactions.
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 rN_req_i  input  1  request from requester N (N=0 core data port, N=1 AES DMA).
REQ-006 rN_addr_i / rN_we_i / rN_be_i / rN_wdata_i  input  32/1/4/32  transaction attributes, held stable while rN_req_i=1 and rN_gnt_o=0.
REQ-007 r1_burst_i  input  1  sampled on a granted r1 beat, requests burst lock.
REQ-008 rN_gnt_o  output  1  transaction accepted this cycle.
REQ-009 rN_rvalid_o / rN_rdata_o  output  1/32  response to requester N, in order.
REQ-010 mem_req_o / mem_addr_o / mem_we_o / mem_be_o / mem_wdata_o  output  1/32/1/4/32  shared memory request.
REQ-011 mem_gnt_i / mem_rvalid_i / mem_rdata_i  input  1/1/32  memory grant and response; one rvalid per granted transaction, read or write.
REQ-012 err_o  output  1  sticky: mem_rvalid_i arrived with no outstanding transaction.

Function
REQ-013 Request path combinational: mem_req_o and attributes driven from the selected requester in the same cycle; rN_gnt_o = mem_gnt_i & mem_req_o & (sel==N).
REQ-014 States ARB and BURST; reset state ARB.
REQ-015 ARB: only one requesting -> select it; both requesting -> select the requester not granted most recently (round-robin pointer, reset value 0, so r0 wins first tie).
REQ-016 Round-robin pointer updates only on a granted beat in ARB.
REQ-017 ARB -> BURST when r1 granted with r1_burst_i=1; beat counter loaded with BURST_LEN-1.
REQ-018 BURST: sel fixed to r1; r0 never granted; counter decrements per r1 grant; counter reaching 0 on a grant -> ARB.
REQ-019 BURST with r1_req_i=0: mem_req_o=0, lock held, no timeout.
REQ-020 Ordering FIFO, depth MAX_OUTST, holds owner id; push on mem_req_o&mem_gnt_i, pop on mem_rvalid_i.
REQ-021 FIFO full -> mem_req_o=0 and both grants 0, regardless of state.
REQ-022 Simultaneous push and pop in one cycle legal when full: count unchanged, grant permitted when pop occurs (full check uses count after pop).
REQ-023 mem_rvalid_i routed combinationally to owner at FIFO head: rN_rvalid_o=1, rN_rdata_o=mem_rdata_i; non-owner rvalid 0, rdata 0.
REQ-024 mem_rvalid_i with FIFO empty -> no rvalid out, no pop, err_o set until reset.
REQ-025 FIFO pointers wrap modulo MAX_OUTST; count width ceil(log2(MAX_OUTST+1)).
REQ-026 No mem_req_o when neither requester eligible; attributes then driven 0.

Reset
REQ-027 rst_ni=0 asynchronously: state ARB, counter 0, pointer 0, FIFO empty, err_o 0.
REQ-028 Reset outputs: all grants, rvalids, mem_req_o 0; data/address outputs 0.
REQ-029 Reset mid-burst or with outstanding transactions discards lock and outstanding ids; later responses from memory trigger REQ-024.

Verification
REQ-030 Both request every cycle, mem_gnt_i=1, 1-cycle rvalid -> grants alternate r0,r1,r0,r1; rdata routed to matching owner.
REQ-031 r1 burst_i=1 read 0x1B8..0x1C4 while r0 requests continuously -> four consecutive r1 grants, r0 granted on fifth cycle.
REQ-032 mem_rvalid_i held 0 for 5 cycles, both requesting -> exactly 2 grants then mem_req_o=0 until an rvalid; pop+grant same cycle observed.
REQ-033 Spurious mem_rvalid_i after reset -> no rN_rvalid_o, err_o=1 next cycle and stays 1.
REQ-034 rst_ni low after second burst beat -> outputs 0 immediately; after release r0 granted on first tie.
REQ-035 r0 write 0xDEADBEEF be=0x3 to 0x188 -> mem_be_o=0x3, mem_wdata_o=0xDEADBEEF, r0_rvalid_o on memory response.
